ysyx_25040111_rf_sb: RTL and testbench
======================================

Name: ysyx_25040111_rf_sb

Overview:
- Parametrised integer register file with an integrated write scoreboard, for the pipelined core. Successor to the single-cycle GPR block.
- Adds busy tracking per register, an issue handshake that stalls on RAW/WAW hazards, writeback bypass, flush of outstanding reservations, and a stall counter.
- Sits between decode/issue (reads and reserves) and writeback (writes and releases).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 16, number of architectural registers; 16 for RV32E, 32 for RV32I; must be a power of 2, ≥2.
- AW, $clog2(NREG), register address width; localparam, not overridable.
- CNTW, 32, stall counter width.

Ports:
- clock in 1: sole clock; all state updates on posedge.
- reset_n in 1: asynchronous, active-low reset.
- iss_valid in 1: issue request this cycle.
- iss_ready out 1: issue accepted when iss_valid && iss_ready.
- iss_ren in 2: bit i enables source i.
- iss_rs1, iss_rs2 in AW: source addresses.
- iss_rd_wen in 1: issuing instruction writes a destination.
- iss_rd in AW: destination address.
- rs1_data, rs2_data out XLEN: source operands.
- wb_valid in 1: writeback this cycle.
- wb_addr in AW: writeback address.
- wb_data in XLEN: writeback data.
- flush in 1: discard all outstanding reservations.
- busy out NREG: scoreboard vector, for debug; bit 0 is always 0.
- stall_cnt out CNTW: count of cycles with iss_valid && !iss_ready.

Behaviour:
- Reset (async, reset_n=0): all rf entries = 0, busy = 0, stall_cnt = 0. Immediately after reset, iss_ready = 1 while flush = 0, and rs*_data = 0.
- x0: reads return 0; writes are ignored; reservations of rd=0 are ignored; busy[0] is never set.
- Read data (combinational, 0-cycle):
  - rsN_data = 0 if iss_ren[N]=0 or addr=0.
  - Otherwise rsN_data = wb_data if wb_valid && wb_addr==addr (bypass).
  - Otherwise rsN_data = rf[addr].
- Hazard terms:
  - src_okN = !iss_ren[N] || addr==0 || !busy[addr] || (wb_valid && wb_addr==addr).
  - dst_ok = !iss_rd_wen || iss_rd==0 || !busy[iss_rd] || (wb_valid && wb_addr==iss_rd).
- iss_ready = src_ok1 && src_ok2 && dst_ok && !flush. It is independent of iss_valid.
- Write: on posedge, if wb_valid && wb_addr!=0, then rf[wb_addr] <= wb_data. This applies whether or not the register is busy; late writebacks after a flush still update data.
- Busy update, per register r≠0, at posedge, in priority order:
  1. flush → busy[r] <= 0, for all r.
  2. Else fire && iss_rd_wen && iss_rd==r → busy[r] <= 1. Reserve wins over a same-cycle release of the same register.
  3. Else wb_valid && wb_addr==r → busy[r] <= 0.
  4. Else hold.
- fire = iss_valid && iss_ready.
- Single outstanding write per register: WAW stalls via dst_ok, so a 1-bit busy flag is sufficient.
- stall_cnt: increments by 1 on each posedge with iss_valid && !iss_ready, including flush cycles. Saturates at all-ones; it never wraps.
- Simultaneous flush and wb_valid: data is written, all busy bits are cleared, and no issue fires.
- Reset asserted mid-operation: the async clear overrides any pending write or reserve in that cycle.

Decomposition:
- Shared package ysyx_25040111_rf_pkg:
  - default XLEN/NREG constants;
  - RV32E/RV32I NREG presets;
  - REG_ZERO = 0 constant.
- Sub-module ysyx_25040111_rf_rdport, instantiated twice:
  - inputs: ren, addr, busy vector, wb bypass signals, rf read value;
  - outputs: data and src_ok.
- Scoreboard, write logic and counter stay in the top module.

Test Plan:
- Reset then idle: iss_ren=2'b11, rs1=3, rs2=0 → rs1_data=0, rs2_data=0, iss_ready=1, busy=0, stall_cnt=0.
- RAW stall and bypass:
  - Issue rd=5 (fire) → next cycle busy[5]=1.
  - Issue rs1=5 with no wb → iss_ready=0, stall_cnt increments.
  - wb_valid, addr=5, data=0xDEADBEEF in the same cycle → iss_ready=1, rs1_data=0xDEADBEEF.
  - Next cycle busy[5]=0 and rf[5]=0xDEADBEEF.
- Same-cycle reserve and release: busy[7]=1; wb addr=7 and fire with rd=7 together → busy[7] stays 1 and rf[7] gets wb_data.
- WAW and x0:
  - busy[9]=1, issue rd=9 → iss_ready=0.
  - Issue rd=0 with wen → fires; busy[0] stays 0.
  - wb addr=0, data=0x1234 → rs1 read of x0 = 0.
- Flush:
  - busy[2], busy[4] set; flush=1 with iss_valid=1 → iss_ready=0.
  - Next cycle busy=0.
  - Late wb addr=4, data=0x55 → rf[4]=0x55, busy[4] stays 0.
- Saturation and async reset: CNTW=4, hold a stall for 20 cycles → stall_cnt=15. Drop reset_n between edges → stall_cnt, busy and rf clear immediately.

Source files
------------

// File: rtl/ysyx_25040111_rf_pkg.sv
// Shared constants for the scoreboarded register file: default widths,
// RV32E/RV32I register-count presets and the hard-wired zero register index.
package ysyx_25040111_rf_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_RV32E   = 16;
    localparam int NREG_RV32I   = 32;
    localparam int NREG_DEFAULT = NREG_RV32E;
    localparam int CNTW_DEFAULT = 32;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/ysyx_25040111_rf_rdport.sv
// One source-operand read port: returns zero for disabled or x0 reads,
// forwards same-cycle writeback data, and reports whether the source is hazard-free.
module ysyx_25040111_rf_rdport
    import ysyx_25040111_rf_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    parameter  int NREG = NREG_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            ren_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [NREG-1:0] busy_i,
    input  logic            wb_valid_i,
    input  logic [AW-1:0]   wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [XLEN-1:0] rf_rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            src_ok_o
);

    logic addrZero;
    logic wbHit;

    assign addrZero = (addr_i == AW'(REG_ZERO));
    assign wbHit    = wb_valid_i && (wb_addr_i == addr_i);

    always_comb begin
        data_o = '0;
        if (ren_i && !addrZero) begin
            data_o = wbHit ? wb_data_i : rf_rdata_i;
        end
    end

    // A busy source is still usable when its pending result arrives this cycle.
    assign src_ok_o = !ren_i || addrZero || !busy_i[addr_i] || wbHit;

endmodule

// File: rtl/ysyx_25040111_rf_sb.sv
// Integer register file with a per-register write scoreboard: issue stalls on
// RAW/WAW hazards, writeback releases reservations, flush drops them all.
module ysyx_25040111_rf_sb
    import ysyx_25040111_rf_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    parameter  int NREG = NREG_DEFAULT,
    parameter  int CNTW = CNTW_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            iss_valid,
    output logic            iss_ready,
    input  logic [1:0]      iss_ren,
    input  logic [AW-1:0]   iss_rs1,
    input  logic [AW-1:0]   iss_rs2,
    input  logic            iss_rd_wen,
    input  logic [AW-1:0]   iss_rd,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic [NREG-1:0] busy,
    output logic [CNTW-1:0] stall_cnt
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [CNTW-1:0] stallCnt_q;
    logic [CNTW-1:0] stallCnt_d;

    logic srcOk1;
    logic srcOk2;
    logic dstOk;
    logic fire;
    logic stallCycle;

    ysyx_25040111_rf_rdport #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rdport1 (
        .ren_i      (iss_ren[0]),
        .addr_i     (iss_rs1),
        .busy_i     (busy_q),
        .wb_valid_i (wb_valid),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .rf_rdata_i (rf_q[iss_rs1]),
        .data_o     (rs1_data),
        .src_ok_o   (srcOk1)
    );

    ysyx_25040111_rf_rdport #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rdport2 (
        .ren_i      (iss_ren[1]),
        .addr_i     (iss_rs2),
        .busy_i     (busy_q),
        .wb_valid_i (wb_valid),
        .wb_addr_i  (wb_addr),
        .wb_data_i  (wb_data),
        .rf_rdata_i (rf_q[iss_rs2]),
        .data_o     (rs2_data),
        .src_ok_o   (srcOk2)
    );

    // WAW check: only one write per register may be in flight at a time.
    assign dstOk = !iss_rd_wen
                || (iss_rd == AW'(REG_ZERO))
                || !busy_q[iss_rd]
                || (wb_valid && (wb_addr == iss_rd));

    assign iss_ready  = srcOk1 && srcOk2 && dstOk && !flush;
    assign fire       = iss_valid && iss_ready;
    assign stallCycle = iss_valid && !iss_ready;

    // Writebacks land even when the register is no longer reserved (post-flush).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                rf_q[r] <= '0;
            end
        end else if (wb_valid && (wb_addr != AW'(REG_ZERO))) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (fire && iss_rd_wen && (iss_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (wb_valid && (wb_addr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        stallCnt_d = stallCnt_q;
        if (stallCycle && (stallCnt_q != {CNTW{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNTW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
        end
    end

    assign busy      = busy_q;
    assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_ysyx_25040111_rf_sb.sv
// Scoreboard bench for the register file: each step queues its expected
// observations, which are popped and compared once the step's outputs settle.
module tb_ysyx_25040111_rf_sb;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int CNTW = 4;
    localparam int AW   = 4;

    localparam int OBS_RS1   = 0;
    localparam int OBS_RS2   = 1;
    localparam int OBS_READY = 2;
    localparam int OBS_BUSY  = 3;
    localparam int OBS_CNT   = 4;

    logic            clock;
    logic            reset_n;
    logic            iss_valid;
    logic            iss_ready;
    logic [1:0]      iss_ren;
    logic [AW-1:0]   iss_rs1;
    logic [AW-1:0]   iss_rs2;
    logic            iss_rd_wen;
    logic [AW-1:0]   iss_rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic [NREG-1:0] busy;
    logic [CNTW-1:0] stall_cnt;

    int checks;
    int failures;
    int cntExp;

    string       tagQ[$];
    int          kindQ[$];
    logic [31:0] expQ[$];

    ysyx_25040111_rf_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .CNTW (CNTW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_ren    (iss_ren),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_rd_wen (iss_rd_wen),
        .iss_rd     (iss_rd),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush),
        .busy       (busy),
        .stall_cnt  (stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic pushExpect(input string tag, input int kind, input logic [31:0] exp);
        tagQ.push_back(tag);
        kindQ.push_back(kind);
        expQ.push_back(exp);
    endtask

    task automatic drainChecks();
        string       tag;
        int          kind;
        logic [31:0] exp;
        logic [31:0] obs;
        while (expQ.size() > 0) begin
            tag  = tagQ.pop_front();
            kind = kindQ.pop_front();
            exp  = expQ.pop_front();
            case (kind)
                OBS_RS1:   obs = rs1_data;
                OBS_RS2:   obs = rs2_data;
                OBS_READY: obs = {31'b0, iss_ready};
                OBS_BUSY:  obs = 32'(busy);
                default:   obs = 32'(stall_cnt);
            endcase
            checkOutput(tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge and let them settle.
    task automatic applyStimulus(input logic iv, input logic [1:0] ren,
                                 input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                 input logic wen, input logic [AW-1:0] rd,
                                 input logic wbv, input logic [AW-1:0] wba,
                                 input logic [XLEN-1:0] wbd, input logic fl);
        @(negedge clock);
        iss_valid  = iv;
        iss_ren    = ren;
        iss_rs1    = rs1;
        iss_rs2    = rs2;
        iss_rd_wen = wen;
        iss_rd     = rd;
        wb_valid   = wbv;
        wb_addr    = wba;
        wb_data    = wbd;
        flush      = fl;
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks     = 0;
        failures   = 0;
        reset_n    = 1'b0;
        iss_valid  = 1'b0;
        iss_ren    = 2'b00;
        iss_rs1    = '0;
        iss_rs2    = '0;
        iss_rd_wen = 1'b0;
        iss_rd     = '0;
        wb_valid   = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        flush      = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Idle after reset
        applyStimulus(0, 2'b11, 3, 0, 0, 0, 0, 0, 0, 0);
        pushExpect("reset_rs1", OBS_RS1, 32'h0);
        pushExpect("reset_rs2", OBS_RS2, 32'h0);
        pushExpect("reset_ready", OBS_READY, 32'h1);
        pushExpect("reset_busy", OBS_BUSY, 32'h0);
        pushExpect("reset_cnt", OBS_CNT, 32'h0);
        drainChecks();

        // RAW stall and writeback bypass on x5
        applyStimulus(1, 2'b00, 0, 0, 1, 5, 0, 0, 0, 0);
        pushExpect("resv5_ready", OBS_READY, 32'h1);
        drainChecks();
        applyStimulus(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0);
        pushExpect("raw_busy", OBS_BUSY, 32'h0020);
        pushExpect("raw_ready", OBS_READY, 32'h0);
        pushExpect("raw_cnt0", OBS_CNT, 32'h0);
        drainChecks();
        applyStimulus(1, 2'b01, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
        pushExpect("raw_cnt1", OBS_CNT, 32'h1);
        pushExpect("byp_ready", OBS_READY, 32'h1);
        pushExpect("byp_rs1", OBS_RS1, 32'hDEADBEEF);
        drainChecks();
        applyStimulus(0, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0);
        pushExpect("rel5_busy", OBS_BUSY, 32'h0);
        pushExpect("rf5_rs1", OBS_RS1, 32'hDEADBEEF);
        drainChecks();

        // Same-cycle reserve and release of x7
        applyStimulus(1, 2'b00, 0, 0, 1, 7, 0, 0, 0, 0);
        pushExpect("resv7_ready", OBS_READY, 32'h1);
        drainChecks();
        applyStimulus(1, 2'b00, 0, 0, 1, 7, 1, 7, 32'hA5A50007, 0);
        pushExpect("rr7_busy", OBS_BUSY, 32'h0080);
        pushExpect("rr7_ready", OBS_READY, 32'h1);
        drainChecks();
        applyStimulus(0, 2'b01, 7, 0, 0, 0, 0, 0, 0, 0);
        pushExpect("rr7_busy_after", OBS_BUSY, 32'h0080);
        pushExpect("rr7_rf", OBS_RS1, 32'hA5A50007);
        pushExpect("ready_no_valid", OBS_READY, 32'h0);
        drainChecks();

        // WAW on x9 and x0 handling
        applyStimulus(1, 2'b00, 0, 0, 1, 9, 0, 0, 0, 0);
        pushExpect("resv9_ready", OBS_READY, 32'h1);
        drainChecks();
        applyStimulus(1, 2'b00, 0, 0, 1, 9, 0, 0, 0, 0);
        pushExpect("waw_busy", OBS_BUSY, 32'h0280);
        pushExpect("waw_ready", OBS_READY, 32'h0);
        drainChecks();
        applyStimulus(1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 0);
        pushExpect("x0_resv_cnt", OBS_CNT, 32'h2);
        pushExpect("x0_resv_ready", OBS_READY, 32'h1);
        drainChecks();
        applyStimulus(0, 2'b01, 0, 0, 0, 0, 1, 0, 32'h00001234, 0);
        pushExpect("x0_busy", OBS_BUSY, 32'h0280);
        pushExpect("x0_byp_rs1", OBS_RS1, 32'h0);
        drainChecks();
        applyStimulus(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
        pushExpect("x0_rf_rs1", OBS_RS1, 32'h0);
        drainChecks();

        // Flush of outstanding reservations
        applyStimulus(1, 2'b00, 5, 7, 1, 2, 0, 0, 0, 0);
        pushExpect("ren_off_rs1", OBS_RS1, 32'h0);
        pushExpect("ren_off_rs2", OBS_RS2, 32'h0);
        pushExpect("resv2_ready", OBS_READY, 32'h1);
        drainChecks();
        applyStimulus(1, 2'b00, 0, 0, 1, 4, 0, 0, 0, 0);
        pushExpect("resv4_busy", OBS_BUSY, 32'h0284);
        pushExpect("resv4_ready", OBS_READY, 32'h1);
        drainChecks();
        applyStimulus(1, 2'b00, 0, 0, 1, 11, 0, 0, 0, 1);
        pushExpect("flush_busy_pre", OBS_BUSY, 32'h0294);
        pushExpect("flush_ready", OBS_READY, 32'h0);
        drainChecks();
        applyStimulus(0, 2'b10, 0, 4, 0, 0, 1, 4, 32'h00000055, 0);
        pushExpect("flush_busy_post", OBS_BUSY, 32'h0);
        pushExpect("flush_cnt", OBS_CNT, 32'h3);
        pushExpect("late_byp_rs2", OBS_RS2, 32'h00000055);
        drainChecks();
        applyStimulus(0, 2'b11, 4, 5, 0, 0, 0, 0, 0, 0);
        pushExpect("late_busy", OBS_BUSY, 32'h0);
        pushExpect("late_rf4", OBS_RS1, 32'h00000055);
        pushExpect("rf5_rs2", OBS_RS2, 32'hDEADBEEF);
        drainChecks();

        // Stall counter saturation on a long RAW stall against x3
        applyStimulus(1, 2'b00, 0, 0, 1, 3, 0, 0, 0, 0);
        pushExpect("resv3_ready", OBS_READY, 32'h1);
        drainChecks();
        cntExp = 3;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0);
            pushExpect($sformatf("sat_cnt_%0d", i), OBS_CNT, 32'(cntExp));
            drainChecks();
            if (cntExp < 15) cntExp++;
        end
        applyStimulus(0, 2'b01, 5, 0, 0, 0, 0, 0, 0, 0);
        pushExpect("sat_cnt_final", OBS_CNT, 32'hF);
        pushExpect("pre_rst_busy", OBS_BUSY, 32'h0008);
        pushExpect("pre_rst_rs1", OBS_RS1, 32'hDEADBEEF);
        drainChecks();

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        pushExpect("async_cnt", OBS_CNT, 32'h0);
        pushExpect("async_busy", OBS_BUSY, 32'h0);
        pushExpect("async_rf5", OBS_RS1, 32'h0);
        drainChecks();
        @(negedge clock);
        reset_n = 1'b1;
        applyStimulus(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0);
        pushExpect("post_rst_ready", OBS_READY, 32'h1);
        pushExpect("post_rst_cnt", OBS_CNT, 32'h0);
        drainChecks();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
